mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data access controller.
// Data normally wins; a saturating starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_mem_req;
  logic        w_mem_req_next;
  logic [31:0] r_mem_addr;
  logic [31:0] w_mem_addr_next;
  logic [31:0] r_mem_wdata;
  logic [31:0] w_mem_wdata_next;
  logic [3:0]  r_mem_we;
  logic [3:0]  w_mem_we_next;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_cnt_next;
  logic        w_force_i;
  logic        w_unused;

  // Byte-lane bits of the requester addresses never reach the memory.
  assign w_unused = &{1'b0, if_addr[1:0], d_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_we     <= 4'h0;
      r_starve_cnt <= 4'h0;
    end else begin
      r_state      <= w_state_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_mem_we     <= w_mem_we_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_mem_req_next    = r_mem_req;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_mem_we_next     = r_mem_we;
    w_starve_cnt_next = r_starve_cnt;
    w_force_i         = if_req && (r_starve_cnt >= LP_STARVE_MAX);
    if_ack            = 1'b0;
    d_ack             = 1'b0;

    case (r_state)
      IDLE: begin
        if (d_req && !w_force_i) begin
          w_state_next     = BUSY_D;
          w_mem_req_next   = 1'b1;
          w_mem_addr_next  = {d_addr[31:2], 2'b00};
          w_mem_wdata_next = d_wdata;
          w_mem_we_next    = d_we;
          if (!if_req) begin
            w_starve_cnt_next = 4'h0;
          end else if (r_starve_cnt != 4'hF) begin
            w_starve_cnt_next = r_starve_cnt + 4'd1;
          end
        end else if (if_req) begin
          w_state_next      = BUSY_I;
          w_mem_req_next    = 1'b1;
          w_mem_addr_next   = {if_addr[31:2], 2'b00};
          w_mem_we_next     = 4'h0;
          w_starve_cnt_next = 4'h0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          if_ack         = 1'b1;
          w_state_next   = IDLE;
          w_mem_req_next = 1'b0;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          d_ack          = 1'b1;
          w_state_next   = IDLE;
          w_mem_req_next = 1'b0;
          w_mem_we_next  = 4'h0;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_mem_req_next = 1'b0;
        w_mem_we_next  = 4'h0;
      end
    endcase
  end

  // Read data is forwarded unconditionally; the acks qualify it.
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios on a STARVE_MAX=4 and a STARVE_MAX=0
// instance, then randomized traffic with random memory wait states against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A (STARVE_MAX=4)
  logic        if_req = 1'b0, d_req = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [3:0]  d_we = '0;
  logic        if_ack, d_ack, mem_req;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;

  // Instance B (STARVE_MAX=0)
  logic        if_req_b = 1'b0, d_req_b = 1'b0, mem_ack_b = 1'b0;
  logic [31:0] if_addr_b = '0, d_addr_b = '0, d_wdata_b = '0, mem_rdata_b = '0;
  logic [3:0]  d_we_b = '0;
  logic        if_ack_b, d_ack_b, mem_req_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_we_b;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] env_mem [256];
  logic [31:0] shadow  [256];
  int          mem_wait = 0;
  bit          mem_rand = 1'b0;
  int          wcnt = 0;

  mem_port_arbiter #(.STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.STARVE_MAX(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
    .d_req(d_req_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_we(d_we_b), .d_ack(d_ack_b), .d_rdata(d_rdata_b),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b)
  );

  // One clock: memories respond just after the rising edge, the task returns on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req) begin
      mem_ack   = mem_rand ? ($urandom_range(0, 2) == 0) : (wcnt >= mem_wait);
      wcnt      = mem_ack ? 0 : wcnt + 1;
      mem_rdata = env_mem[mem_addr[9:2]];
      if (mem_ack) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) env_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end else begin
      mem_ack   = 1'b0;
      wcnt      = 0;
      mem_rdata = $urandom;
    end
    mem_ack_b   = mem_req_b;
    mem_rdata_b = $urandom;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    n_checks++; if (mem_we !== 4'h0) begin n_errors++; $display("FAIL rst_mem_we got=%h want=0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_errors++; $display("FAIL rst_mem_addr_wdata got=%h/%h want=0/0", mem_addr, mem_wdata); end
    n_checks++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin n_errors++; $display("FAIL rst_acks got=%b%b want=00", if_ack, d_ack); end
    n_checks++; if (mem_req_b !== 1'b0) begin n_errors++; $display("FAIL rst_mem_req_b got=%b want=0", mem_req_b); end
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    #1;
    n_checks++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin n_errors++; $display("FAIL idle_mem_ack got=%b%b want=00", if_ack, d_ack); end
    mem_ack = 1'b0;
  endtask

  task automatic test_single_fetch();
    env_mem[0] = 32'hDEAD_BEEF;
    if_req  = 1'b1;
    if_addr = 32'h0000_1003;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_we !== 4'h0) begin n_errors++; $display("FAIL fetch_issue got req=%b addr=%h we=%h want 1/00001000/0", mem_req, mem_addr, mem_we); end
    n_checks++; if (if_ack !== 1'b1 || d_ack !== 1'b0) begin n_errors++; $display("FAIL fetch_ack got=%b%b want=10", if_ack, d_ack); end
    n_checks++; if (if_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL fetch_rdata got=%h want=deadbeef", if_rdata); end
    if_req = 1'b0;
    tick();
    n_checks++; if (mem_req !== 1'b0 || if_ack !== 1'b0) begin n_errors++; $display("FAIL fetch_idle got req=%b ack=%b want 0/0", mem_req, if_ack); end
  endtask

  task automatic test_tie();
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    d_req   = 1'b1;
    d_addr  = 32'h0000_0020;
    d_we    = 4'b0011;
    d_wdata = 32'h0000_ABCD;
    tick();
    n_checks++; if (mem_addr !== 32'h20 || mem_we !== 4'b0011 || mem_wdata !== 32'h0000_ABCD) begin n_errors++; $display("FAIL tie_data_issue got addr=%h we=%h wd=%h want 20/3/0000abcd", mem_addr, mem_we, mem_wdata); end
    n_checks++; if (d_ack !== 1'b1 || if_ack !== 1'b0) begin n_errors++; $display("FAIL tie_data_ack got i=%b d=%b want 0/1", if_ack, d_ack); end
    d_req = 1'b0;
    d_we  = 4'h0;
    tick();
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 4'h0 || if_ack !== 1'b0) begin n_errors++; $display("FAIL tie_bubble got req=%b we=%h iack=%b want 0/0/0", mem_req, mem_we, if_ack); end
    tick();
    n_checks++; if (if_ack !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 4'h0) begin n_errors++; $display("FAIL tie_fetch got ack=%b addr=%h we=%h want 1/40/0", if_ack, mem_addr, mem_we); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int grants;
    int streak;
    bit exp_d;
    grants  = 0;
    streak  = 0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    d_req   = 1'b1;
    d_addr  = 32'h0000_0044;
    d_we    = 4'h0;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      tick();
      if (if_ack || d_ack) begin
        exp_d = (streak < 4);
        n_checks++; if (d_ack !== exp_d || if_ack !== !exp_d) begin n_errors++; $display("FAIL starve_grant%0d got i=%b d=%b want i=%b d=%b", grants, if_ack, d_ack, !exp_d, exp_d); end
        streak = exp_d ? streak + 1 : 0;
        grants++;
      end
    end
    n_checks++; if (grants != 6) begin n_errors++; $display("FAIL starve_count got=%0d grants want=6", grants); end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    mem_wait = 3;
    d_req    = 1'b1;
    d_addr   = 32'h0000_0086;
    d_we     = 4'hF;
    d_wdata  = 32'h1234_5678;
    tick();
    if_req   = 1'b1;
    if_addr  = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h84 || mem_we !== 4'hF || mem_wdata !== 32'h1234_5678) begin n_errors++; $display("FAIL wait_stable%0d got req=%b addr=%h we=%h wd=%h", i, mem_req, mem_addr, mem_we, mem_wdata); end
      n_checks++; if (d_ack !== (i == 3) || if_ack !== 1'b0) begin n_errors++; $display("FAIL wait_ack%0d got d=%b i=%b want d=%b i=0", i, d_ack, if_ack, (i == 3)); end
    end
    d_req    = 1'b0;
    d_we     = 4'h0;
    mem_wait = 0;
    tick();
    n_checks++; if (mem_req !== 1'b0 || if_ack !== 1'b0) begin n_errors++; $display("FAIL wait_bubble got req=%b iack=%b want 0/0", mem_req, if_ack); end
    tick();
    n_checks++; if (if_ack !== 1'b1 || mem_addr !== 32'h200) begin n_errors++; $display("FAIL wait_fetch got ack=%b addr=%h want 1/200", if_ack, mem_addr); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    mem_wait = 5;
    d_req    = 1'b1;
    d_addr   = 32'h0000_0030;
    d_we     = 4'h0;
    tick();
    tick();
    n_checks++; if (mem_req !== 1'b1 || d_ack !== 1'b0) begin n_errors++; $display("FAIL rmid_busy got req=%b dack=%b want 1/0", mem_req, d_ack); end
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0 || d_ack !== 1'b0) begin n_errors++; $display("FAIL rmid_abort got req=%b dack=%b want 0/0", mem_req, d_ack); end
    mem_ack = 1'b0;
    tick();
    tick();
    rst_n      = 1'b1;
    mem_wait   = 0;
    env_mem[12] = 32'hCAFE_F00D;
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h30 || d_ack !== 1'b1) begin n_errors++; $display("FAIL rmid_regrant got req=%b addr=%h dack=%b want 1/30/1", mem_req, mem_addr, d_ack); end
    n_checks++; if (d_rdata !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL rmid_rdata got=%h want=cafef00d", d_rdata); end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_starve0_tie();
    int fetches;
    fetches   = 0;
    if_req_b  = 1'b1;
    if_addr_b = 32'h0000_0010;
    d_req_b   = 1'b1;
    d_addr_b  = 32'h0000_0014;
    d_we_b    = 4'h0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if_ack_b || d_ack_b) begin
        n_checks++; if (if_ack_b !== 1'b1 || d_ack_b !== 1'b0) begin n_errors++; $display("FAIL s0_tie%0d got i=%b d=%b want 1/0", c, if_ack_b, d_ack_b); end
        fetches++;
      end
    end
    n_checks++; if (fetches != 5) begin n_errors++; $display("FAIL s0_fetches got=%0d want=5", fetches); end
    if_req_b = 1'b0;
    tick();
    n_checks++; if (d_ack_b !== 1'b1 || if_ack_b !== 1'b0 || mem_addr_b !== 32'h14) begin n_errors++; $display("FAIL s0_data got d=%b i=%b addr=%h want 1/0/14", d_ack_b, if_ack_b, mem_addr_b); end
    d_req_b = 1'b0;
    tick();
  endtask

  // Random traffic: the model tracks who owns the memory and the run of data grants made while fetch waited.
  task automatic test_random();
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_streak;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_we;
    bit          e_iack, e_dack, was_idle, forced;
    m_owner  = 0;
    m_streak = 0;
    m_addr   = '0;
    m_wdata  = '0;
    m_we     = '0;
    if_req   = 1'b0;
    d_req    = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h0;
      shadow[i]  = 32'h0;
    end
    tick();
    rst_n    = 1'b1;
    mem_rand = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      n_checks++; if (mem_req !== (m_owner != 0)) begin n_errors++; $display("FAIL rnd_req c=%0d got=%b want=%b", c, mem_req, (m_owner != 0)); end
      if (m_owner != 0) begin
        n_checks++; if (mem_addr !== m_addr || mem_we !== m_we) begin n_errors++; $display("FAIL rnd_cmd c=%0d got addr=%h we=%h want %h/%h", c, mem_addr, mem_we, m_addr, m_we); end
        if (m_owner == 2) begin
          n_checks++; if (mem_wdata !== m_wdata) begin n_errors++; $display("FAIL rnd_wdata c=%0d got=%h want=%h", c, mem_wdata, m_wdata); end
        end
      end
      e_iack = (m_owner == 1) && (mem_ack === 1'b1);
      e_dack = (m_owner == 2) && (mem_ack === 1'b1);
      n_checks++; if (if_ack !== e_iack || d_ack !== e_dack) begin n_errors++; $display("FAIL rnd_ack c=%0d got i=%b d=%b want i=%b d=%b", c, if_ack, d_ack, e_iack, e_dack); end
      if (e_iack) begin
        n_checks++; if (if_rdata !== shadow[if_addr[9:2]]) begin n_errors++; $display("FAIL rnd_if_rdata c=%0d got=%h want=%h", c, if_rdata, shadow[if_addr[9:2]]); end
      end
      if (e_dack) begin
        if (d_we == 4'h0) begin
          n_checks++; if (d_rdata !== shadow[d_addr[9:2]]) begin n_errors++; $display("FAIL rnd_d_rdata c=%0d got=%h want=%h", c, d_rdata, shadow[d_addr[9:2]]); end
        end else begin
          for (int b = 0; b < 4; b++)
            if (d_we[b]) shadow[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end
      end
      was_idle = (m_owner == 0);
      if (m_owner != 0 && mem_ack === 1'b1) m_owner = 0;
      if (e_iack || !if_req) begin
        if_req  = ($urandom_range(0, 1) == 1);
        if_addr = $urandom & 32'hFFFF_FC3F;
      end
      if (e_dack || !d_req) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_addr  = $urandom & 32'hFFFF_FC3F;
        d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        d_wdata = $urandom;
      end
      if (was_idle) begin
        forced = if_req && (m_streak >= 4);
        if (d_req && !forced) begin
          m_owner  = 2;
          m_addr   = {d_addr[31:2], 2'b00};
          m_we     = d_we;
          m_wdata  = d_wdata;
          m_streak = if_req ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
        end else if (if_req) begin
          m_owner  = 1;
          m_addr   = {if_addr[31:2], 2'b00};
          m_we     = 4'h0;
          m_streak = 0;
        end
      end
    end
    mem_rand = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = 32'h0;
    test_reset();
    test_single_fetch();
    test_tie();
    test_starvation();
    test_wait_states();
    test_reset_mid_op();
    test_starve0_tie();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
